// File: rtl/imem_stream_loader.sv
// imem_stream_loader: receives a framed byte stream (4-byte length N, N little-endian
//   words, 1 XOR checksum byte) and writes each word into instruction memory.
// Latency: each word's write strobe appears the cycle after its 4th byte is accepted.
//   o_done and o_cpu_hold=0 appear the cycle after a matching checksum byte.
// Backpressure: o_rx_ready is high while framing (length/data/checksum) unless i_start
//   is high. It drops in DONE/ERR. Accepts 1 byte/cycle, including during write cycles.
// Ports: i_clk/i_reset (sync, active-high), i_start (abort + restart framing),
//   i_rx_valid/i_rx_data/o_rx_ready (byte stream),
//   o_imem_we/o_imem_addr/o_imem_wdata (memory write),
//   o_cpu_hold/o_done/o_err/o_words_loaded (status).
module imem_stream_loader #(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_words_loaded
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] len_q;      // N, shifted in LSB first
  logic [31:0] k_q;        // index of the word currently being assembled
  logic [1:0]  b_q;        // byte index within the length field or the current word
  logic [7:0]  acc_q;      // running XOR of every accepted frame byte
  logic [23:0] word_sr;    // first three bytes of the current word
  logic        we_q;

  logic        framing;
  logic        xfer;
  logic [31:0] len_next;
  logic [31:0] word_next;
  logic        last_word;

  assign framing    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign o_rx_ready = framing & ~i_start;
  assign xfer       = i_rx_valid & o_rx_ready;

  // Bytes arrive LSB first, so each new byte enters at the top.
  assign len_next  = {i_rx_data, len_q[31:8]};
  assign word_next = {i_rx_data, word_sr};
  assign last_word = (k_q == len_q - 32'd1);

  // The strobe is also masked in the cycle it is visible. A reset or start landing on the
  // cycle after a word completes must cancel that write, not just the next one.
  assign o_imem_we = we_q & ~i_reset & ~i_start;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= S_LEN;
      len_q          <= '0;
      k_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      word_sr        <= '0;
      we_q           <= 1'b0;
      o_imem_addr    <= BASE_ADDR;
      o_imem_wdata   <= '0;
      o_cpu_hold     <= 1'b1;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_words_loaded <= '0;
    end else if (i_start) begin
      state_q        <= S_LEN;
      len_q          <= '0;
      k_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      word_sr        <= '0;
      we_q           <= 1'b0;
      o_cpu_hold     <= 1'b1;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_words_loaded <= '0;
    end else begin
      we_q <= 1'b0;
      if (xfer) begin
        acc_q <= acc_q ^ i_rx_data;
      end
      case (state_q)
        S_LEN: begin
          if (xfer) begin
            len_q <= len_next;
            b_q   <= b_q + 2'd1;
            if (b_q == 2'd3) begin
              if (len_next > 32'(DEPTH_WORDS)) begin
                state_q <= S_ERR;
                o_err   <= 1'b1;
              end else if (len_next == 32'd0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_sr <= word_next[31:8];
            b_q     <= b_q + 2'd1;
            if (b_q == 2'd3) begin
              we_q           <= 1'b1;
              o_imem_addr    <= BASE_ADDR + (k_q << 2);
              o_imem_wdata   <= word_next;
              o_words_loaded <= o_words_loaded + 16'd1;
              k_q            <= k_q + 32'd1;
              if (last_word) begin
                state_q <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (i_rx_data == acc_q) begin
              state_q    <= S_DONE;
              o_done     <= 1'b1;
              o_cpu_hold <= 1'b0;
            end else begin
              state_q <= S_ERR;
              o_err   <= 1'b1;
            end
          end
        end
        S_DONE: state_q <= S_DONE;
        S_ERR:  state_q <= S_ERR;
        default: begin
          state_q <= S_ERR;
          o_err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rdy;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        hold;
  logic        done;
  logic        err;
  logic [15:0] wl;

  int total = 0;
  int bad = 0;
  int wr_count = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } wr_t;

  wr_t exp_q[$];
  logic [31:0] frame_words[4];

  imem_stream_loader #(.DEPTH_WORDS(2048), .BASE_ADDR(BASE)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_rx_valid     (rx_valid),
    .i_rx_data      (rx_data),
    .o_rx_ready     (rdy),
    .o_imem_we      (we),
    .o_imem_addr    (addr),
    .o_imem_wdata   (wdata),
    .o_cpu_hold     (hold),
    .o_done         (done),
    .o_err          (err),
    .o_words_loaded (wl)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_t e;
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h required=none", addr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (addr !== e.addr || wdata !== e.data || wl !== e.cnt) begin
          bad++;
          $display("FAIL write addr=%h data=%h cnt=%0d required addr=%h data=%h cnt=%0d",
                   addr, wdata, wl, e.addr, e.data, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gap);
    int n = 0;
    if (gap) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = d;
    #0;
    while (rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL send_byte_timeout ready=%b required=1", rdy);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_frame(input int n, input bit gap, input logic [7:0] flip);
    logic [7:0]  cs = 8'h00;
    logic [31:0] nn = 32'(n);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      cs ^= nn[8*i +: 8];
      send_byte(nn[8*i +: 8], gap);
    end
    for (int k = 0; k < n; k++) begin
      w = frame_words[k];
      exp_q.push_back('{BASE + 32'(4 * k), w, 16'(k + 1)});
      for (int i = 0; i < 4; i++) cs ^= w[8*i +: 8];
      send_word(w, gap);
    end
    send_byte(cs ^ flip, gap);
  endtask

  task automatic pulse_start(input bit junk);
    start = 1'b1;
    if (junk) begin
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
    end
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL start_ready ready=%b required=0", rdy); end
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    total++; if (hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || wl !== 16'd0) begin
      bad++; $display("FAIL start_state hold=%b done=%b err=%b wl=%0d required 1 0 0 0", hold, done, err, wl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL reset_hold got=%b required=1", hold); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags done=%b err=%b required 0 0", done, err); end
    total++; if (we !== 1'b0 || addr !== BASE || wdata !== 32'h0) begin
      bad++; $display("FAIL reset_bus we=%b addr=%h wdata=%h required 0 %h 0", we, addr, wdata, BASE);
    end
    total++; if (wl !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d required=0", wl); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required=1", rdy); end
  endtask

  task automatic check_good(input string name, input int wc0, input int nwr);
    total++; if (done !== 1'b1 || hold !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL %s_status done=%b hold=%b err=%b required 1 0 0", name, done, hold, err);
    end
    total++; if (wl !== 16'(nwr)) begin bad++; $display("FAIL %s_count got=%0d required=%0d", name, wl, nwr); end
    total++; if (wr_count - wc0 != nwr) begin bad++; $display("FAIL %s_writes got=%0d required=%0d", name, wr_count - wc0, nwr); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL %s_missing_writes got=%0d required=0", name, exp_q.size()); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL %s_ready got=%b required=0", name, rdy); end
  endtask

  task automatic test_basic();
    int wc0 = wr_count;
    frame_words[0] = 32'h0050_0093;
    frame_words[1] = 32'h00A0_0113;
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL basic_hold_before got=%b required=1", hold); end
    send_frame(2, 1'b0, 8'h00);
    check_good("basic", wc0, 2);
  endtask

  task automatic test_toggle();
    int wc0;
    pulse_start(1'b1);
    wc0 = wr_count;
    send_frame(2, 1'b1, 8'h00);
    check_good("toggle", wc0, 2);
  endtask

  task automatic test_bad_csum();
    int wc0;
    pulse_start(1'b0);
    wc0 = wr_count;
    send_frame(2, 1'b0, 8'h01);
    tick();
    total++; if (err !== 1'b1 || done !== 1'b0 || hold !== 1'b1) begin
      bad++; $display("FAIL badcsum_status err=%b done=%b hold=%b required 1 0 1", err, done, hold);
    end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL badcsum_ready got=%b required=0", rdy); end
    total++; if (wr_count - wc0 != 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL badcsum_writes got=%0d pending=%0d required 2 0", wr_count - wc0, exp_q.size());
    end
  endtask

  task automatic test_len_err();
    int wc0;
    logic [31:0] nn = 32'h0000_0801;
    pulse_start(1'b0);
    wc0 = wr_count;
    for (int i = 0; i < 4; i++) send_byte(nn[8*i +: 8], 1'b0);
    total++; if (err !== 1'b1 || done !== 1'b0 || hold !== 1'b1) begin
      bad++; $display("FAIL lenerr_status err=%b done=%b hold=%b required 1 0 1", err, done, hold);
    end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL lenerr_ready got=%b required=0", rdy); end
    repeat (3) tick();
    total++; if (wr_count != wc0) begin bad++; $display("FAIL lenerr_writes got=%0d required=0", wr_count - wc0); end
  endtask

  task automatic test_zero_len();
    int wc0;
    pulse_start(1'b0);
    wc0 = wr_count;
    send_frame(0, 1'b0, 8'h00);
    check_good("zero", wc0, 0);
  endtask

  task automatic test_restart();
    int wc0;
    logic [31:0] nn = 32'd2;
    logic [31:0] w1 = 32'h5566_7788;
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) send_byte(nn[8*i +: 8], 1'b0);
    exp_q.push_back('{BASE, 32'h1122_3344, 16'd1});
    send_word(32'h1122_3344, 1'b0);
    send_byte(w1[7:0], 1'b0);
    send_byte(w1[15:8], 1'b0);
    pulse_start(1'b1);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL restart_first_word pending=%0d required=0", exp_q.size()); end
    wc0 = wr_count;
    frame_words[0] = 32'hDEAD_BEEF;
    send_frame(1, 1'b0, 8'h00);
    check_good("restart", wc0, 1);
  endtask

  task automatic test_reset_mid();
    int wc0;
    logic [31:0] nn = 32'd2;
    logic [31:0] w = 32'hCAFE_F00D;
    pulse_start(1'b0);
    wc0 = wr_count;
    for (int i = 0; i < 4; i++) send_byte(nn[8*i +: 8], 1'b0);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    rst = 1'b1;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rstmid_strobe got=%b required=0", we); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL rstmid_status hold=%b done=%b err=%b required 1 0 0", hold, done, err);
    end
    total++; if (we !== 1'b0 || addr !== BASE || wdata !== 32'h0 || wl !== 16'd0) begin
      bad++; $display("FAIL rstmid_bus we=%b addr=%h wdata=%h wl=%0d required 0 %h 0 0", we, addr, wdata, wl, BASE);
    end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b required=1", rdy); end
    repeat (3) tick();
    total++; if (wr_count != wc0) begin bad++; $display("FAIL rstmid_writes got=%0d required=0", wr_count - wc0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_bad_csum();
    test_len_err();
    test_zero_len();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
